stopwatch_core: RTL
===================

STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 Parameter CLOCK_HZ, default 12_000_000: input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 10: count resolution in Hz; CLOCK_HZ/TICK_HZ SHALL be an integer of at least 2.
REQ-003 Parameter MIN_DIGITS, default 1, legal 1..2: number of BCD minute digits.
REQ-004 Port list (name, direction, width, meaning):
- clock, in, 1: single clock; all logic on its rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- start_stop, in, 1: one-cycle pulse, already debounced.
- clear, in, 1: one-cycle pulse, already debounced.
- lap, in, 1: one-cycle pulse, already debounced.
- mode_down, in, 1: 1 = countdown, 0 = count-up.
- preset, in, 4*(3+MIN_DIGITS): BCD countdown start value {min, ten_sec, sec, subsec}.
- disp_time, out, 4*(3+MIN_DIGITS): BCD display value, same packing as preset.
- running, out, 1: 1 while in state RUNNING.
- lap_active, out, 1: 1 while the display is frozen.
- done, out, 1: one-cycle pulse when a countdown reaches zero.

Function
REQ-005 The FSM SHALL have exactly four states: IDLE, RUNNING, PAUSED and DONE.
REQ-006 Transitions on start_stop SHALL be: IDLE->RUNNING, RUNNING->PAUSED, PAUSED->RUNNING; start_stop SHALL be ignored in DONE.
REQ-007 In IDLE with the latched mode = down and time = 0, start_stop SHALL be ignored.
REQ-008 clear SHALL move any state to IDLE on the next edge; it loads time with 0 (mode_down=0) or preset (mode_down=1), zeroes the prescaler and releases lap.
REQ-009 clear SHALL win over start_stop and lap in the same cycle.
REQ-010 mode_down SHALL be latched only in IDLE; changes in other states SHALL have no effect.
REQ-011 The prescaler SHALL count 0..CLOCK_HZ/TICK_HZ-1 only in RUNNING and SHALL hold in PAUSED, so fractional progress is kept.
REQ-012 A tick SHALL occur on the cycle the prescaler is at its top value; the prescaler then wraps to 0.
REQ-013 On the first RUNNING cycle the prescaler SHALL be 0; the first tick SHALL update time exactly CLOCK_HZ/TICK_HZ cycles after the start_stop edge.
REQ-014 Digit ranges SHALL be: subsec 0..9, sec 0..9, ten_sec 0..5, each minute digit 0..9; carry and borrow SHALL ripple within the tick cycle.
REQ-015 Up mode at the maximum value (9:59.9 with MIN_DIGITS=1, 99:59.9 with MIN_DIGITS=2) SHALL wrap to all-zero and keep running.
REQ-016 Down mode: a tick taking time to zero SHALL enter DONE on that same edge and assert done for exactly one cycle; time SHALL hold at 0.
REQ-017 running SHALL be registered and equal (state==RUNNING).
REQ-018 disp_time SHALL show live time, or the lap capture while lap_active=1.

Reset
REQ-019 reset_n low SHALL asynchronously force state=IDLE, time=0, prescaler=0, latched mode=up, disp_time=0, running=0, lap_active=0, done=0.
REQ-020 Release SHALL be synchronous to clock; an assertion mid-count SHALL discard all progress.

Configuration
REQ-021 Macro STOPWATCH_LAP_EN defined: lap in RUNNING or PAUSED SHALL toggle lap_active; lap_active 0->1 SHALL capture live time into the lap register on that edge; counting SHALL continue underneath; lap in IDLE or DONE SHALL be ignored.
REQ-022 Macro STOPWATCH_LAP_EN undefined: the lap register SHALL be absent, lap SHALL be ignored, lap_active SHALL be constant 0, and disp_time SHALL always equal live time.

Verification
All scenarios use CLOCK_HZ=100, TICK_HZ=10 (10 cycles per tick), MIN_DIGITS=1.
REQ-023 Up count: reset, then start_stop, then 10 cycles -> disp_time=0:00.1; after 600 ticks total -> 1:00.0.
REQ-024 Pause/resume: start, 15 cycles, start_stop, wait 50 cycles, start_stop, 5 cycles -> time=0:00.2, with exactly 2 ticks and none while PAUSED.
REQ-025 Wrap: preload by running 5999 ticks, one more tick -> 0:00.0 with running=1; done SHALL never assert.
REQ-026 Countdown: mode_down=1, preset=0:00.3, clear, start_stop -> done pulses once 30 cycles later, state DONE, disp 0:00.0, and a further start_stop is ignored.
REQ-027 Priority/reset: clear and start_stop in the same cycle while RUNNING -> IDLE, time 0; reset_n low mid-run -> all outputs 0 immediately, without waiting for a clock edge.
REQ-028 Lap (STOPWATCH_LAP_EN defined): lap at 0:00.4 -> disp held at 0:00.4 for 50 cycles; second lap -> disp=0:00.9.

Source files
------------

// File: rtl/stopwatch_core.sv
// stopwatch_core: BCD stopwatch / countdown timer; define STOPWATCH_LAP_EN to add the lap-freeze display
module stopwatch_core #(
  parameter int CLOCK_HZ   = 12_000_000,
  parameter int TICK_HZ    = 10,
  parameter int MIN_DIGITS = 1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        start_stop,
  input  logic                        clear,
  input  logic                        lap,
  input  logic                        mode_down,
  input  logic [4*(3+MIN_DIGITS)-1:0] preset,
  output logic [4*(3+MIN_DIGITS)-1:0] disp_time,
  output logic                        running,
  output logic                        lap_active,
  output logic                        done
);
  localparam int N   = 3 + MIN_DIGITS;
  localparam int W   = 4 * N;
  localparam int DIV = CLOCK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, DONE} state_t;
  state_t         state, state_nxt;
  logic [W-1:0]   time_q, time_step;
  logic [PW-1:0]  presc;
  logic           mode, tick, carry;
  function automatic logic [3:0] dmax(input int i);
    return (i == 2) ? 4'd5 : 4'd9;
  endfunction
  assign tick = state == RUNNING && presc == PW'(DIV - 1);
  // one BCD step (up or down by latched mode), carry/borrow rippling from subsec upward
  always_comb begin
    time_step = time_q;
    carry = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (carry) begin
        if (mode) begin
          time_step[4*i+:4] = (time_q[4*i+:4] == 4'd0) ? dmax(i) : time_q[4*i+:4] - 4'd1;
          carry = time_q[4*i+:4] == 4'd0;
        end else begin
          time_step[4*i+:4] = (time_q[4*i+:4] == dmax(i)) ? 4'd0 : time_q[4*i+:4] + 4'd1;
          carry = time_q[4*i+:4] == dmax(i);
        end
      end
    end
  end
  // next state; a countdown tick reaching zero beats a simultaneous pause, clear beats everything
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_stop && !(mode && time_q == '0)) state_nxt = RUNNING;
      RUNNING: if (tick && mode && time_step == '0) state_nxt = DONE;
               else if (start_stop) state_nxt = PAUSED;
      PAUSED:  if (start_stop) state_nxt = RUNNING;
      DONE:    state_nxt = DONE;
    endcase
    if (clear) state_nxt = IDLE;
  end
  // state register
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  // time, prescaler (frozen outside RUNNING), latched mode and registered status flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      time_q  <= '0;
      presc   <= '0;
      mode    <= 1'b0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      if (clear) begin
        time_q <= mode_down ? preset : '0;
        presc  <= '0;
      end else if (state == RUNNING) begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick) time_q <= time_step;
      end
      if (clear || state == IDLE) mode <= mode_down;
      running <= state_nxt == RUNNING;
      done    <= state == RUNNING && state_nxt == DONE;
    end
  end
`ifdef STOPWATCH_LAP_EN
  logic [W-1:0] lap_time;
  logic         lap_on;
  // lap toggles the frozen display; entering the freeze captures the live time
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lap_on   <= 1'b0;
      lap_time <= '0;
    end else if (clear) begin
      lap_on <= 1'b0;
    end else if (lap && (state == RUNNING || state == PAUSED)) begin
      lap_on <= !lap_on;
      if (!lap_on) lap_time <= time_q;
    end
  end
  assign lap_active = lap_on;
  assign disp_time  = lap_on ? lap_time : time_q;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_active = 1'b0;
  assign disp_time  = time_q;
`endif
endmodule
